jtframe_linedbl: RTL
====================

Name: jtframe_linedbl

Overview:
- Scan doubler that sits directly downstream of the video timer and the game's pixel mixer.
- Takes one 15 kHz line of pixels plus LHBL/LVBL/HS/VS and stores it in a ping-pong line RAM.
- Replays each stored line twice at double pixel rate, producing 31 kHz video with regenerated HS and aligned blanking for VGA-style outputs.

Parameters:
- DW, 12: RGB input/output width; three equal channels of DW/3 bits.
- AW, 9: line RAM address width; maximum line length is 2**AW input pixels.
- HS_LEN, 32: output HS pulse width, in pxl2_cen ticks.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- pxl_cen  in  1  input pixel clock enable
- pxl2_cen  in  1  output pixel clock enable, twice the pxl_cen rate; every pxl_cen coincides with a pxl2_cen
- LHBL  in  1  input horizontal blank, active low
- LVBL  in  1  input vertical blank, active low
- HS  in  1  input horizontal sync, active high
- VS  in  1  input vertical sync, active high
- rgb_in  in  DW  input pixel
- rgb_out  out  DW  doubled pixel
- LHBL_out  out  1  output horizontal blank, active low
- LVBL_out  out  1  output vertical blank, active low
- HS_out  out  1  output horizontal sync
- VS_out  out  1  output vertical sync
- ovf  out  1  sticky flag: a line exceeded 2**AW pixels

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active high.
- Reset values:
  - all outputs 0, including LVBL_out=0 and LHBL_out=0 (screen blanked);
  - ovf=0; FSM in IDLE; hcnt=0; hlen=0; write bank 0.
- Input side, on pxl_cen:
  - Detect the HS rising edge (previous HS registered on pxl_cen).
  - On an edge: latch hlen=hcnt+1, reset hcnt to 0, toggle the write bank, and sample LVBL and VS into line registers.
  - Otherwise: hcnt increments, saturating at 2**AW-1.
  - Each pxl_cen writes {LHBL, rgb_in} to address hcnt of the write bank.
  - If hcnt saturates: writes stop, ovf is set, and ovf stays set until rst.
- Output FSM, states IDLE, LINE_A, LINE_B; transitions are evaluated on pxl2_cen:
  - IDLE: leave on the second HS rising edge after reset (hlen is then valid) and go to LINE_A.
  - Any input HS rising edge, in any non-IDLE state: go to LINE_A, set rcnt=0, select read bank = the bank just completed. This has priority over every other transition.
  - LINE_A: rcnt increments; when rcnt==hlen-1, go to LINE_B with rcnt=0.
  - LINE_B: rcnt increments up to hlen-1, then holds there with output forced blank (LHBL_out=0) until the next HS edge.
- Read latency: the RAM read takes 1 pxl2_cen tick. The HS_out, LVBL_out and VS_out paths are delayed one stage to match the data.
- HS_out: 1 while rcnt<HS_LEN in LINE_A or LINE_B, measured on the delayed stage.
- LHBL_out: the stored LHBL bit read back from RAM.
- LVBL_out and VS_out: the sampled line values, held for both LINE_A and LINE_B.
- rgb_out: RAM data when LHBL_out && LVBL_out, otherwise 0.
- Line-length limit: if hlen exceeds 2**AW, read addresses clamp to 2**AW-1.
- A mid-frame rst returns the block to IDLE. Outputs stay blanked until two HS edges have been seen.

Optional Feature:
- Macro: JTFRAME_LINEDBL_SCANLINE_EN.
- Defined: in LINE_B each channel of rgb_out is shifted right by 1 bit (50% brightness, simulated scanlines); sync and blank outputs are unchanged.
- Undefined: LINE_B output is identical to LINE_A.

Decomposition:
- Package jtframe_linedbl_pkg holds the FSM state enum (IDLE/LINE_A/LINE_B) and the channel-width localparam DW/3.
- Sub-module jtframe_linedbl_ram:
  - two banks of 2**AW x (DW+1);
  - one write port driven on pxl_cen;
  - one read port with registered output, 1-cycle latency;
  - a bank-select input on each port.

Test Plan:
- Reset, then drive a 396-pixel line (HS high at pixels 30..39): outputs stay 0 until the 2nd HS edge, then LINE_A starts with rcnt=0.
- Steady state, line N carries a ramp rgb_in=pixel index: the output emits the ramp twice per input line, each copy 396 pxl2 ticks long, with one tick of latency after the HS edge.
- Check sync and blank output: HS_out is high for exactly 32 pxl2 ticks at the start of each output line; LHBL_out=0 for the 116 stored blank pixels; rgb_out=0 there.
- Vertical path: LVBL=0 during input lines 239..254 gives LVBL_out=0 and rgb_out=0 on the corresponding 32 output lines; VS on lines 244..247 gives VS_out on 8 output lines.
- Overflow: feed a 600-pixel line with AW=9. Expect ovf=1 and staying 1; read addresses clamp at 511; the output FSM still resyncs on the next HS.
- With JTFRAME_LINEDBL_SCANLINE_EN and rgb_in=12'hFFF: LINE_A outputs FFF and LINE_B outputs 777. Without the macro, both lines output FFF.

Source files
------------

// File: rtl/jtframe_linedbl_pkg.sv
// jtframe_linedbl_pkg: output FSM states and channel-width helper for the scan doubler
package jtframe_linedbl_pkg;
  typedef enum logic [1:0] {IDLE, LINE_A, LINE_B} state_t;
  localparam int LDBL_DW = 12;
  function automatic int chan_w(input int dw);
    return dw / 3;
  endfunction
endpackage

// File: rtl/jtframe_linedbl_ram.sv
// jtframe_linedbl_ram: two-bank line buffer, write port on pxl_cen, registered 1-tick read port
module jtframe_linedbl_ram #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_wbank,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW:0]   i_wdata,
  input  logic          i_re,
  input  logic          i_rbank,
  input  logic [AW-1:0] i_raddr,
  output logic [DW:0]   o_rdata
);
  logic [DW:0] r_mem [2**(AW+1)];
  always_ff @(posedge clk)
    if (i_we) r_mem[{i_wbank, i_waddr}] <= i_wdata;
  always_ff @(posedge clk)
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[{i_rbank, i_raddr}];
endmodule

// File: rtl/jtframe_linedbl.sv
// jtframe_linedbl: 15 kHz to 31 kHz scan doubler; JTFRAME_LINEDBL_SCANLINE_EN dims the repeated line
module jtframe_linedbl
  import jtframe_linedbl_pkg::*;
#(
  parameter int DW     = LDBL_DW,
  parameter int AW     = 9,
  parameter int HS_LEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          pxl2_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic          HS,
  input  logic          VS,
  input  logic [DW-1:0] rgb_in,
  output logic [DW-1:0] rgb_out,
  output logic          LHBL_out,
  output logic          LVBL_out,
  output logic          HS_out,
  output logic          VS_out,
  output logic          ovf
);
  localparam int CW = chan_w(DW);
  state_t        r_state, w_nstate;
  logic          r_hs_l, r_wbank, r_full, r_ovf, r_lvbl, r_vs;
  logic [AW-1:0] r_hcnt, w_raddr;
  logic [AW:0]   r_hlen, r_rcnt, w_nrcnt;
  logic          r_hold, w_nhold, r_seen, w_nseen, r_rbank, w_nrbank;
  logic          r_d_vis, r_d_hs, r_d_lvbl, r_d_vs;
  logic          w_edge, w_last, w_act;
  logic [DW:0]   w_q;
  logic [DW-1:0] w_pix;
  assign w_edge = pxl_cen & HS & ~r_hs_l;
  assign w_last = r_rcnt == r_hlen - 1'b1;
  assign w_act  = r_state != IDLE;
  assign w_raddr = r_rcnt[AW] ? '1 : r_rcnt[AW-1:0];
  // r_full blocks further writes for the rest of an over-long line
  always_ff @(posedge clk)
    if (rst) begin
      r_hs_l  <= 1'b0;
      r_hcnt  <= '0;
      r_hlen  <= '0;
      r_wbank <= 1'b0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_lvbl  <= 1'b0;
      r_vs    <= 1'b0;
    end else if (pxl_cen) begin
      r_hs_l <= HS;
      if (w_edge) begin
        r_hlen  <= {1'b0, r_hcnt} + 1'b1;
        r_hcnt  <= '0;
        r_wbank <= ~r_wbank;
        r_full  <= 1'b0;
        r_lvbl  <= LVBL;
        r_vs    <= VS;
      end else if (&r_hcnt) begin
        r_full <= 1'b1;
        r_ovf  <= 1'b1;
      end else r_hcnt <= r_hcnt + 1'b1;
    end
  jtframe_linedbl_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (pxl_cen & ~r_full),
    .i_wbank (r_wbank),
    .i_waddr (r_hcnt),
    .i_wdata ({LHBL, rgb_in}),
    .i_re    (pxl2_cen),
    .i_rbank (r_rbank),
    .i_raddr (w_raddr),
    .o_rdata (w_q)
  );
  always_comb begin
    w_nstate = r_state;
    w_nrcnt  = r_rcnt;
    w_nhold  = r_hold;
    w_nseen  = r_seen;
    w_nrbank = r_rbank;
    if (w_edge && (r_seen || w_act)) begin
      w_nstate = LINE_A;
      w_nrcnt  = '0;
      w_nhold  = 1'b0;
      w_nrbank = r_wbank;
    end else if (w_edge) w_nseen = 1'b1;
    else if (w_act && !w_last) w_nrcnt = r_rcnt + 1'b1;
    else if (r_state == LINE_A) begin
      w_nstate = LINE_B;
      w_nrcnt  = '0;
    end else if (r_state == LINE_B) w_nhold = 1'b1;
  end
  // delayed stage lines sync/blank up with the registered RAM read
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_rcnt   <= '0;
      r_hold   <= 1'b0;
      r_seen   <= 1'b0;
      r_rbank  <= 1'b0;
      r_d_vis  <= 1'b0;
      r_d_hs   <= 1'b0;
      r_d_lvbl <= 1'b0;
      r_d_vs   <= 1'b0;
    end else if (pxl2_cen) begin
      r_state  <= w_nstate;
      r_rcnt   <= w_nrcnt;
      r_hold   <= w_nhold;
      r_seen   <= w_nseen;
      r_rbank  <= w_nrbank;
      r_d_vis  <= w_act & ~r_hold;
      r_d_hs   <= w_act && r_rcnt < (AW+1)'(HS_LEN);
      r_d_lvbl <= w_act & r_lvbl;
      r_d_vs   <= w_act & r_vs;
    end
  assign ovf      = r_ovf;
  assign LHBL_out = w_q[DW] & r_d_vis;
  assign LVBL_out = r_d_lvbl;
  assign HS_out   = r_d_hs;
  assign VS_out   = r_d_vs;
  assign w_pix    = w_q[DW-1:0];
`ifdef JTFRAME_LINEDBL_SCANLINE_EN
  logic          r_d_b;
  logic [DW-1:0] w_dim;
  always_ff @(posedge clk)
    if (rst) r_d_b <= 1'b0;
    else if (pxl2_cen) r_d_b <= r_state == LINE_B;
  for (genvar c = 0; c < 3; c++) begin : g_dim
    assign w_dim[c*CW +: CW] = {1'b0, w_pix[c*CW+1 +: CW-1]};
  end
  assign rgb_out = (LHBL_out & LVBL_out) ? (r_d_b ? w_dim : w_pix) : '0;
`else
  assign rgb_out = (LHBL_out & LVBL_out) ? w_pix : '0;
`endif
endmodule
